// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter and presents it to instruction
// memory. It registers the returned word for decode, and handles branch
// redirect, stall and halt on ECALL.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned branch target halts the core. When it is undefined, the low
// two bits of the branch target are cleared.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic        misaligned
);

  localparam logic [1:0]  ST_BOOT     = 2'd0;
  localparam logic [1:0]  ST_RUN      = 2'd1;
  localparam logic [1:0]  ST_HALT     = 2'd2;
  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_instr_nxt;
  logic        if_valid_nxt;
  logic        halted_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_q;
  logic        misaligned_nxt;
`endif

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_pc_nxt    = if_pc;
    if_instr_nxt = if_instr;
    if_valid_nxt = if_valid;
    halted_nxt   = halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_nxt = misaligned_q;
`endif
    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (branch_target[1:0] != 2'b00) begin
            state_nxt      = ST_HALT;
            halted_nxt     = 1'b1;
            misaligned_nxt = 1'b1;
            if_valid_nxt   = 1'b0;
            if_instr_nxt   = NOP_INSTR;
          end else
`endif
          begin
            pc_nxt       = branch_target & ALIGN_MASK;
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
          end
        end else if (!stall) begin
          if_pc_nxt    = pc;
          if_instr_nxt = instr;
          if_valid_nxt = 1'b1;
          if (instr == ECALL_INSTR) begin
            state_nxt  = ST_HALT;
            halted_nxt = 1'b1;
          end else begin
            pc_nxt = pc + PC_STEP;
          end
        end
      end
      ST_HALT: begin
        if_valid_nxt = 1'b0;
        if_instr_nxt = NOP_INSTR;
        halted_nxt   = 1'b1;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // State and fetch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      if_pc    <= 32'h0000_0000;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
      halted   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      if_pc    <= if_pc_nxt;
      if_instr <= if_instr_nxt;
      if_valid <= if_valid_nxt;
      halted   <= halted_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_nxt;
`endif
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. It has three parts: directed vectors from
// a table, a randomized run checked against a reference model, and a
// pc wrap check on a second instance.
module tb_instruction_fetch;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target, instr;
  logic [31:0] pc, if_pc, if_instr;
  logic        if_valid, halted, misaligned;

  logic        w_reset;
  logic [31:0] w_pc, w_if_pc, w_if_instr;
  logic        w_if_valid, w_halted, w_misaligned;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign instr = mem[pc[7:2]];

  instruction_fetch u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr(instr), .pc(pc), .if_pc(if_pc),
    .if_instr(if_instr), .if_valid(if_valid), .halted(halted),
    .misaligned(misaligned)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0000_0000), .instr(32'h0000_0093), .pc(w_pc),
    .if_pc(w_if_pc), .if_instr(w_if_instr), .if_valid(w_if_valid),
    .halted(w_halted), .misaligned(w_misaligned)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_if_pc;
    logic [31:0] e_ins;
    logic        e_v;
    logic        e_h;
    logic        e_m;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic stl, input logic br, input logic [31:0] tgt,
                     input logic [31:0] e_pc, input logic [31:0] e_if_pc, input logic [31:0] e_ins,
                     input logic e_v, input logic e_h, input logic e_m);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_if_pc = e_if_pc; v.e_ins = e_ins;
    v.e_v = e_v; v.e_h = e_h; v.e_m = e_m;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_if_pc,
                           input logic [31:0] e_ins, input logic e_v, input logic e_h, input logic e_m);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".if_pc"}, if_pc, e_if_pc);
    chk({tag, ".if_instr"}, if_instr, e_ins);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(e_v));
    chk({tag, ".halted"}, 32'(halted), 32'(e_h));
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(e_m));
  endtask

  // Reference model: fetch behaviour described by flags and plain arithmetic.
  logic        m_boot, m_halt, m_valid, m_mis;
  logic [31:0] m_pc, m_if_pc, m_if_instr;

  task automatic model_step(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
    logic [31:0] w;
    if (rst) begin
      m_boot = 1'b1; m_halt = 1'b0; m_pc = 32'h0; m_if_pc = 32'h0;
      m_if_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0; m_if_instr = NOP;
    end else if (br) begin
      m_valid = 1'b0; m_if_instr = NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt % 4 != 0) begin
        m_halt = 1'b1; m_mis = 1'b1;
      end else m_pc = tgt;
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else if (!stl) begin
      w = mem[m_pc[7:2]];
      m_if_pc = m_pc; m_if_instr = w; m_valid = 1'b1;
      if (w == ECALL) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 + (32'(i) << 20);
    mem[0] = 32'h003100B3; mem[1] = 32'h0010A0A3; mem[2] = 32'h0010A203;
    mem[3] = ECALL;        mem[4] = 32'h0040_0093; mem[5] = 32'h0050_0113;
    mem[6] = 32'h0060_0193;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    w_reset = 1'b1;

    //   rst stl br  tgt   pc   if_pc  if_instr      v  h  m
    add(1, 0, 0, 0,     0,   0,  NOP,           0, 0, 0); // reset
    add(0, 0, 0, 0,     0,   0,  NOP,           0, 0, 0); // boot edge
    add(0, 0, 0, 0,     4,   0,  32'h003100B3,  1, 0, 0);
    add(0, 0, 0, 0,     8,   4,  32'h0010A0A3,  1, 0, 0);
    add(0, 1, 0, 0,     8,   4,  32'h0010A0A3,  1, 0, 0); // stall x3
    add(0, 1, 0, 0,     8,   4,  32'h0010A0A3,  1, 0, 0);
    add(0, 1, 0, 0,     8,   4,  32'h0010A0A3,  1, 0, 0);
    add(0, 0, 0, 0,     12,  8,  32'h0010A203,  1, 0, 0);
    add(0, 1, 1, 16,    16,  8,  NOP,           0, 0, 0); // stall+branch redirects
    add(0, 0, 1, 20,    20,  8,  NOP,           0, 0, 0); // flush word @16
    add(0, 0, 0, 0,     24,  20, 32'h0050_0113, 1, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    add(0, 0, 1, 6,     24,  20, NOP,           0, 1, 1); // misaligned trap
    add(0, 0, 1, 8,     24,  20, NOP,           0, 1, 1); // branch ignored in halt
`else
    add(0, 0, 1, 6,     4,   20, NOP,           0, 0, 0); // target forced to 4
    add(0, 0, 0, 0,     8,   4,  32'h0010A0A3,  1, 0, 0);
    add(0, 0, 0, 0,     12,  8,  32'h0010A203,  1, 0, 0);
    add(0, 0, 0, 0,     12,  12, ECALL,         1, 1, 0); // ECALL latched
    add(0, 0, 1, 0,     12,  12, NOP,           0, 1, 0); // branch ignored
    add(0, 1, 0, 0,     12,  12, NOP,           0, 1, 0);
`endif
    add(1, 0, 0, 0,     0,   0,  NOP,           0, 0, 0); // reset from halt

    foreach (tbl[i]) begin
      reset = tbl[i].rst; stall = tbl[i].stl;
      branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_if_pc, tbl[i].e_ins,
                tbl[i].e_v, tbl[i].e_h, tbl[i].e_m);
    end

    // Randomized run against the model.
    for (int c = 0; c < 400; c++) begin
      reset         = (c == 0) || ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      branch_target = $urandom_range(0, 255);
      model_step(reset, stall, branch_taken, branch_target);
      tick();
      check_all($sformatf("rnd%0d", c), m_pc, m_if_pc, m_if_instr, m_valid, m_halt, m_mis);
    end

    // Wrap instance: reset, boot, then two fetches across 2^32.
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    w_reset = 1'b1;
    tick();
    chk("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
    w_reset = 1'b0;
    tick();
    tick();
    chk("wrap.if_pc1", w_if_pc, 32'hFFFF_FFFC);
    chk("wrap.pc1", w_pc, 32'h0000_0000);
    tick();
    chk("wrap.if_pc2", w_if_pc, 32'h0000_0000);
    chk("wrap.pc2", w_pc, 32'h0000_0004);
    chk("wrap.valid", 32'(w_if_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the non-pipelined/pipelined RISC-V core. Owns the program counter and drives it to `instruction_memory` as a byte address. Captures the returned 32-bit word into a fetch register (`if_pc`, `if_instr`, `if_valid`) consumed by the decoder. Handles branch redirect, stall, and halt on ECALL.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, word placed in `if_instr` whenever the fetch register is invalid (`addi x0,x0,0`).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and fetch register this cycle.
- branch_taken  input  1  single-cycle redirect request from execute.
- branch_target  input  32  redirect byte address, valid when `branch_taken`=1.
- instr  input  32  word returned combinationally by `instruction_memory` for `pc`.
- pc  output  32  current fetch address, driven to `instruction_memory`.
- if_pc  output  32  address of the word in `if_instr`.
- if_instr  output  32  fetched instruction for decode.
- if_valid  output  1  `if_instr` is a real instruction.
- halted  output  1  core has stopped fetching.
- misaligned  output  1  halt was caused by a misaligned branch target (see Configuration).

## Operation
- States: BOOT, RUN, HALT. `pc` is a register; `instr` is sampled the same cycle `pc` is presented.
- Reset (edge with `reset`=1, overrides everything): state=BOOT, pc=RESET_PC, if_pc=0, if_instr=NOP_INSTR, if_valid=0, halted=0, misaligned=0.
- BOOT: exactly one cycle. Nothing is latched, pc holds. Next state is RUN. `stall` and `branch_taken` are ignored.
- RUN, evaluated in priority order each edge:
  1. `branch_taken`=1: pc<=branch_target, if_valid<=0, if_instr<=NOP_INSTR (flush). Applies even when `stall`=1.
  2. `stall`=1: pc, if_pc, if_instr, and if_valid all hold.
  3. Otherwise: if_pc<=pc, if_instr<=instr, if_valid<=1, pc<=pc+4.
- ECALL: in case 3, if instr==32'h0000_0073, the word is latched with if_valid=1, pc holds, and the next state is HALT. A branch in the same cycle wins, and no halt occurs.
- HALT: halted=1. On the first HALT edge, if_valid<=0 and if_instr<=NOP_INSTR. pc and if_pc hold. `stall` and `branch_taken` are ignored. Only `reset` exits HALT.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.

## Timing
- Fetch latency is 0 cycles from `pc` to `instr` (combinational memory). `if_*` updates 1 edge after `pc` is presented.
- After reset deasserts: edge 1 leaves BOOT; edge 2 sets if_valid=1 with if_pc=RESET_PC.
- Branch penalty is one bubble. The edge with `branch_taken` flushes; the following edge latches the target word.
- Steady state: one instruction per cycle when `stall`=0.
- Reset asserted mid-stall, mid-branch, or in HALT: the reset values above apply on that edge.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - `branch_taken` with branch_target[1:0]!=0 in RUN does not update pc.
  - Sets if_valid<=0, state<=HALT, halted=1, misaligned=1.
  - misaligned clears only on reset.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - branch_target[1:0] is forced to 2'b00 before loading pc.
  - `misaligned` is tied to 0.

## Test plan
- Sequential fetch:
  - Stimulus: memory model holds 0x003100B3 @0, 0x0010A0A3 @4, 0x0010A203 @8. Release reset.
  - Response: if_valid rises on edge 2. if_pc/if_instr sequence is 0/0x003100B3, 4/0x0010A0A3, 8/0x0010A203. pc ends at 12.
- Branch flush:
  - Stimulus: pulse branch_taken with target 20 while pc=16.
  - Response: next edge gives if_valid=0 and if_instr=0x00000013. Following edge gives if_pc=20. Word @16 is never valid.
- Stall:
  - Stimulus: hold stall for 3 cycles at pc=8.
  - Response: pc=8 and if_* unchanged for 3 edges. Then if_pc=8. Stall plus branch in the same cycle still redirects.
- ECALL halt:
  - Stimulus: place 0x00000073 @12.
  - Response: if_instr=0x00000073 with if_valid=1 for one cycle. Then if_valid=0, halted=1, pc=12. A branch_taken pulse afterwards has no effect. Reset restores pc=0 and halted=0.
- Wrap:
  - Stimulus: set RESET_PC=32'hFFFF_FFFC.
  - Response: second fetched if_pc is 0x00000000.
- Misaligned target 0x6:
  - With macro: halted=1, misaligned=1, pc unchanged.
  - Without macro: pc=4, misaligned=0.
